// File: rtl/div_pkg.sv
// div_seq_n shared types.
// State codes double as the externally visible CS value.
package div_pkg;

   localparam int CS_W = 4;

   typedef enum logic [CS_W-1:0] {
      IDLE = 4'd0,
      LOAD = 4'd1,
      ITER = 4'd2,
      FIX  = 4'd3,
      DONE = 4'd8
   } state_t;

   // Count register width for a WIDTH-step iteration (min 1 bit).
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/div_seq_n_if.sv
// div_seq_n request/result bundle.
// master drives operands, slave returns results and status.
interface div_seq_n_if #(
   parameter int WIDTH = 8
);
   import div_pkg::*;

   logic             go;
   logic             sgn;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [CS_W-1:0]  CS;
   logic             done;
   logic             error;
   logic             ovf;
   logic             busy;

   modport master (
      output go, sgn, x, y,
      input  q, r, CS, done, error, ovf, busy
   );

   modport slave (
      input  go, sgn, x, y,
      output q, r, CS, done, error, ovf, busy
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division step, MSB first.
// The shifted remainder is WIDTH+1 bits so the compare sees the full value.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_msb,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   assign w_shift = {i_rem, i_msb};
   assign o_qbit  = (w_shift >= {1'b0, i_dvs});
   // Result of a taken subtract is below the divisor, so it fits WIDTH bits.
   assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
   assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_seq_n.sv
// Sequential restoring divider, one quotient bit per clock.
// Unsigned or two's-complement operands, div-by-zero and overflow flags.
module div_seq_n
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic         CLK,
   input logic         RST,
   div_seq_n_if.slave  bus
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   state_t           w_nxt;

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_sgn;
   logic [WIDTH-1:0] r_dq;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_rem;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_err;
   logic             r_ovf;

   logic             w_xneg;
   logic             w_yneg;
   logic [WIDTH-1:0] w_xabs;
   logic [WIDTH-1:0] w_yabs;
   logic [WIDTH-1:0] w_rem_nxt;
   logic             w_qbit;
   logic             w_neg_q;
   logic             w_neg_r;
   logic [WIDTH-1:0] w_qfix;
   logic [WIDTH-1:0] w_rfix;
   logic             w_ovf;
   logic             w_yzero;

   assign w_xneg  = r_sgn & r_x[WIDTH-1];
   assign w_yneg  = r_sgn & r_y[WIDTH-1];
   assign w_xabs  = w_xneg ? (~r_x + 1'b1) : r_x;
   assign w_yabs  = w_yneg ? (~r_y + 1'b1) : r_y;
   assign w_yzero = (r_y == '0);

   // Quotient truncates toward zero; remainder follows the dividend sign.
   assign w_neg_q = w_xneg ^ w_yneg;
   assign w_neg_r = w_xneg;
   assign w_qfix  = w_neg_q ? (~r_dq + 1'b1) : r_dq;
   assign w_rfix  = w_neg_r ? (~r_rem + 1'b1) : r_rem;
   // Most-negative / -1 wraps back to most-negative in the quotient.
   assign w_ovf   = r_sgn & (r_x == MIN_NEG) & (r_y == '1);

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem  (r_rem),
      .i_msb  (r_dq[WIDTH-1]),
      .i_dvs  (r_dvs),
      .o_rem  (w_rem_nxt),
      .o_qbit (w_qbit)
   );

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         IDLE: if (bus.go) w_nxt = LOAD;
         LOAD: w_nxt = w_yzero ? DONE : ITER;
         ITER: if (r_cnt == '0) w_nxt = FIX;
         FIX:  w_nxt = DONE;
         DONE: w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_x   <= '0;
         r_y   <= '0;
         r_sgn <= 1'b0;
         r_dq  <= '0;
         r_dvs <= '0;
         r_rem <= '0;
         r_cnt <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_err <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.go) begin
                  r_x   <= bus.x;
                  r_y   <= bus.y;
                  r_sgn <= bus.sgn;
               end
            end
            LOAD: begin
               r_ovf <= 1'b0;
               if (w_yzero) begin
                  r_q   <= '1;
                  r_r   <= r_x;
                  r_err <= 1'b1;
               end else begin
                  r_err <= 1'b0;
                  r_dq  <= w_xabs;
                  r_dvs <= w_yabs;
                  r_rem <= '0;
                  r_cnt <= CNT_INIT;
               end
            end
            ITER: begin
               r_rem <= w_rem_nxt;
               r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            FIX: begin
               r_q   <= w_qfix;
               r_r   <= w_rfix;
               r_ovf <= w_ovf;
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.q     = r_q;
   assign bus.r     = r_r;
   assign bus.CS    = r_state;
   assign bus.done  = (r_state == DONE);
   assign bus.error = r_err;
   assign bus.ovf   = r_ovf;
   assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_div_seq_n.sv
// Bench for div_seq_n: WIDTH=8 directed cases, WIDTH=4 full sweep.
// An arithmetic reference model drives a per-cycle compare process.
module tb_div_seq_n;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   div_seq_n_if #(.WIDTH(8)) if8 ();
   div_seq_n_if #(.WIDTH(4)) if4 ();

   div_seq_n #(.WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(if8));
   div_seq_n #(.WIDTH(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer division with the documented special cases.
   function automatic void model(input int w, input bit s,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output bit e, output bit o);
      longint sx, sy, mask, lq, lr;
      mask = (longint'(1) << w) - 1;
      sx = longint'(x);
      sy = longint'(y);
      if (s && x[w-1]) sx = sx - (longint'(1) << w);
      if (s && y[w-1]) sy = sy - (longint'(1) << w);
      e = (sy == 0);
      o = s && (sx == -(longint'(1) << (w-1))) && (sy == -1);
      if (e) begin
         lq = mask;
         lr = longint'(x);
      end else begin
         lq = sx / sy;
         lr = sx % sy;
      end
      q = 32'(lq & mask);
      r = 32'(lr & mask);
   endfunction

   // Timing model: k = cycles since accept (0 = idle), done at k == lat.
   int k8 = 0, lat8 = 0, k4 = 0, lat4 = 0;
   logic [31:0] eq8, er8, hq8, hr8, eq4, er4, hq4, hr4;
   bit ee8, eo8, he8, ho8, ee4, eo4, he4, ho4;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         k8 = 0; hq8 = 0; hr8 = 0; he8 = 0; ho8 = 0;
         k4 = 0; hq4 = 0; hr4 = 0; he4 = 0; ho4 = 0;
      end else begin
         if (k8 == 0) begin
            if (if8.go) begin
               model(8, if8.sgn, 32'(if8.x), 32'(if8.y), eq8, er8, ee8, eo8);
               lat8 = ee8 ? 2 : 11;
               k8 = 1;
            end
         end else if (k8 == lat8) begin
            k8 = 0;
         end else begin
            k8++;
            if (k8 == lat8) begin
               hq8 = eq8; hr8 = er8; he8 = ee8; ho8 = eo8;
            end
         end
         if (k4 == 0) begin
            if (if4.go) begin
               model(4, if4.sgn, 32'(if4.x), 32'(if4.y), eq4, er4, ee4, eo4);
               lat4 = ee4 ? 2 : 7;
               k4 = 1;
            end
         end else if (k4 == lat4) begin
            k4 = 0;
         end else begin
            k4++;
            if (k4 == lat4) begin
               hq4 = eq4; hr4 = er4; he4 = ee4; ho4 = eo4;
            end
         end
      end
   end

   // Per-cycle compare of both DUTs against the model.
   always @(negedge CLK) begin
      if (RST) begin
         chk("rst8_cs", 32'(if8.CS), 0);
         chk("rst8_busy", 32'(if8.busy), 0);
         chk("rst4_cs", 32'(if4.CS), 0);
         chk("rst4_busy", 32'(if4.busy), 0);
      end else begin
         chk("done8", 32'(if8.done), 32'(k8 != 0 && k8 == lat8));
         chk("busy8", 32'(if8.busy), 32'(k8 != 0));
         if (k8 == 0) chk("cs8_idle", 32'(if8.CS), 0);
         if (k8 == 0 || k8 == lat8) begin
            if (k8 != 0) chk("cs8_done", 32'(if8.CS), 8);
            chk("q8", 32'(if8.q), hq8);
            chk("r8", 32'(if8.r), hr8);
            chk("err8", 32'(if8.error), 32'(he8));
            chk("ovf8", 32'(if8.ovf), 32'(ho8));
         end
         chk("done4", 32'(if4.done), 32'(k4 != 0 && k4 == lat4));
         chk("busy4", 32'(if4.busy), 32'(k4 != 0));
         if (k4 != 0 && k4 == lat4) begin
            chk("cs4_done", 32'(if4.CS), 8);
            chk("q4", 32'(if4.q), hq4);
            chk("r4", 32'(if4.r), hr4);
            chk("err4", 32'(if4.error), 32'(he4));
            chk("ovf4", 32'(if4.ovf), 32'(ho4));
         end
      end
   end

   task automatic run8(input bit s, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] xq, input logic [7:0] xr,
                       input bit xe, input bit xo, input int xlat);
      int lat, bc;
      @(negedge CLK);
      if8.go = 1'b1; if8.sgn = s; if8.x = x; if8.y = y;
      @(negedge CLK);
      if8.go = 1'b0; if8.x = ~x; if8.y = ~y; if8.sgn = ~s;
      lat = 1; bc = 0;
      while (!if8.done && lat < 20) begin
         if (if8.busy) bc++;
         @(negedge CLK);
         lat++;
      end
      if (!if8.done) begin
         chk("timeout8", 0, 1);
      end else begin
         if (if8.busy) bc++;
         chk("lat8", 32'(lat), 32'(xlat));
         chk("busycnt8", 32'(bc), 32'(xlat));
         chk("lit_q8", 32'(if8.q), 32'(xq));
         chk("lit_r8", 32'(if8.r), 32'(xr));
         chk("lit_err8", 32'(if8.error), 32'(xe));
         chk("lit_ovf8", 32'(if8.ovf), 32'(xo));
      end
   endtask

   task automatic run4(input bit s, input logic [3:0] x, input logic [3:0] y);
      int n;
      @(negedge CLK);
      if4.go = 1'b1; if4.sgn = s; if4.x = x; if4.y = y;
      @(negedge CLK);
      if4.go = 1'b0;
      n = 1;
      while (!if4.done && n < 16) begin
         @(negedge CLK);
         n++;
      end
      if (!if4.done) chk("timeout4", 0, 1);
   endtask

   logic [31:0] pq, pr;
   bit pe, po;

   initial begin
      if8.go = 0; if8.sgn = 0; if8.x = 0; if8.y = 0;
      if4.go = 0; if4.sgn = 0; if4.x = 0; if4.y = 0;
      repeat (3) @(negedge CLK);
      chk("reset_q8", 32'(if8.q), 0);
      chk("reset_done8", 32'(if8.done), 0);
      #3 RST = 1'b0;

      model(8, 0, 200, 7, pq, pr, pe, po);
      chk("pin_u_q", pq, 28);
      chk("pin_u_r", pr, 4);
      model(8, 1, 32'hF9, 32'h02, pq, pr, pe, po);
      chk("pin_s_q", pq, 32'hFD);
      chk("pin_s_r", pr, 32'hFF);
      model(4, 1, 32'h8, 32'hF, pq, pr, pe, po);
      chk("pin_ovf_q", pq, 32'h8);
      chk("pin_ovf_o", 32'(po), 1);
      model(8, 0, 32'h5A, 0, pq, pr, pe, po);
      chk("pin_dz_q", pq, 32'hFF);
      chk("pin_dz_e", 32'(pe), 1);

      run8(0, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 11);
      run8(1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0, 11);
      run8(1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0, 11);
      run8(0, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1, 0, 2);
      run8(1, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1, 0, 2);
      run8(1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, 11);
      run8(0, 8'd100, 8'd9, 8'd11, 8'd1, 0, 0, 11);

      // go pulse and operand change mid-ITER must be ignored.
      @(negedge CLK);
      if8.go = 1; if8.sgn = 0; if8.x = 8'd200; if8.y = 8'd7;
      @(negedge CLK);
      if8.go = 0;
      repeat (3) @(negedge CLK);
      if8.go = 1; if8.x = 8'd3; if8.y = 8'd1;
      @(negedge CLK);
      if8.go = 0;
      begin
         int n;
         n = 0;
         while (!if8.done && n < 20) begin
            @(negedge CLK);
            n++;
         end
         chk("ign_done", 32'(if8.done), 1);
         chk("ign_q", 32'(if8.q), 28);
         chk("ign_r", 32'(if8.r), 4);
      end

      // Asynchronous reset in the middle of ITER.
      @(negedge CLK);
      @(negedge CLK);
      if8.go = 1; if8.x = 8'd201; if8.y = 8'd5;
      @(negedge CLK);
      if8.go = 0;
      repeat (4) @(negedge CLK);
      chk("pre_rst_busy", 32'(if8.busy), 1);
      #2 RST = 1'b1;
      #1;
      chk("arst_cs", 32'(if8.CS), 0);
      chk("arst_q", 32'(if8.q), 0);
      chk("arst_r", 32'(if8.r), 0);
      chk("arst_busy", 32'(if8.busy), 0);
      chk("arst_done", 32'(if8.done), 0);
      chk("arst_err", 32'(if8.error), 0);
      chk("arst_ovf", 32'(if8.ovf), 0);
      @(negedge CLK);
      #3 RST = 1'b0;
      run8(0, 8'd9, 8'd3, 8'd3, 8'd0, 0, 0, 11);

      for (int s = 0; s < 2; s++)
         for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
               run4(s[0], 4'(xi), 4'(yi));

      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
